mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT, default 15, max BUSY cycles to wait for bus_ack before abort (1..255).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset is asynchronous and active-high.
REQ-004 memwritem  input  1  MEM-stage store request from the EX/MEM register.
REQ-005 memtoregm  input  1  MEM-stage load request from the EX/MEM register.
REQ-006 aluoutm  input  32  byte address of access.
REQ-007 writedatam  input  32  store data.
REQ-008 bus_ack  input  1  memory completion strobe, one cycle.
REQ-009 bus_rdata  input  32  read data, valid only with bus_ack.
REQ-010 bus_req  output  1  registered request, held until ack or abort.
REQ-011 bus_we  output  1  registered; 1 = write.
REQ-012 bus_addr  output  32  registered word-aligned address.
REQ-013 bus_wdata  output  32  registered store data.
REQ-014 readdatam  output  32  registered load result to MEM/WB.
REQ-015 stallm  output  1  combinational; freezes IF..EX/MEM registers while high.
REQ-016 misalignm  output  1  one-cycle fault pulse, misaligned access.
REQ-017 buserrm  output  1  one-cycle fault pulse, bus timeout.

Function
REQ-018 Access requested when acc = memwritem | memtoregm; memwritem=1 SHALL take priority (write) when both are high.
REQ-019 FSM states: IDLE, BUSY, DONE.
REQ-020 IDLE, acc=1, aluoutm[1:0]==0: SHALL latch bus_addr=aluoutm, bus_wdata=writedatam, bus_we=memwritem, set bus_req=1, clear counter, go BUSY.
REQ-021 IDLE, acc=1, aluoutm[1:0]!=0: SHALL NOT request bus; misalignm=1 for this cycle; readdatam<=0 at next edge; stay IDLE; stallm=0.
REQ-022 stallm SHALL be 1 in IDLE when acc=1 and aligned, 1 throughout BUSY, 0 in DONE and otherwise.
REQ-023 BUSY: bus_req, bus_we, bus_addr, bus_wdata SHALL remain stable; counter increments each cycle without ack.
REQ-024 BUSY with bus_ack=1: bus_req<=0; readdatam<=bus_rdata if load, unchanged if store; go DONE.
REQ-025 BUSY, counter==TIMEOUT-1 and no ack: bus_req<=0, readdatam<=0, buserrm=1 during following DONE cycle, go DONE.
REQ-026 bus_ack coincident with timeout cycle SHALL be treated as ack (no buserrm).
REQ-027 DONE: exactly one cycle, stallm=0 so the pipeline advances; SHALL NOT start a new access even though acc may be high; go IDLE.
REQ-028 bus_ack outside BUSY SHALL be ignored.
REQ-029 Latency: ack in first BUSY cycle gives 2 stall cycles; ack after n BUSY cycles gives n+1 stall cycles; readdatam valid in DONE cycle.
REQ-030 readdatam SHALL hold its value until the next completed load, fault, or reset.

Reset
REQ-031 reset=1 SHALL immediately force state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, readdatam=0, counter=0, misalignm/buserrm=0, stallm=0, regardless of clock.
REQ-032 Reset during BUSY SHALL abandon the transaction; a later bus_ack SHALL be ignored.

Verification
REQ-033 Load aluoutm=0x100, memtoregm=1, ack after 3 BUSY cycles with bus_rdata=0xDEADBEEF -> bus_req 3 cycles, bus_we=0, stallm 4 cycles, readdatam=0xDEADBEEF in DONE.
REQ-034 Store aluoutm=0x20, writedatam=0x12345678, immediate ack -> bus_we=1, bus_addr=0x20, bus_wdata=0x12345678, stallm 2 cycles, readdatam unchanged.
REQ-035 Load aluoutm=0x103 -> misalignm=1 one cycle, bus_req never asserted, stallm=0, readdatam=0.
REQ-036 Load, no ack, TIMEOUT=15 -> bus_req 15 cycles then 0, buserrm=1 one cycle, readdatam=0, stallm 16 cycles.
REQ-037 Assert reset in 2nd BUSY cycle, then ack -> bus_req falls same cycle as reset, state IDLE, readdatam=0, ack ignored.
REQ-038 Back-to-back store then load, both immediate ack -> DONE separates them, second bus_req rises in cycle after DONE, no lost or duplicated access.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage bus access sequencer: issues one word-aligned load/store per
// instruction, stalls the pipeline until ack or timeout, and flags faults.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwritem,
  input  logic        memtoregm,
  input  logic [31:0] aluoutm,
  input  logic [31:0] writedatam,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [31:0] readdatam,
  output logic        stallm,
  output logic        misalignm,
  output logic        buserrm
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_is_load;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_buserr;

  logic w_acc;
  logic w_aligned;

  assign w_acc     = memwritem | memtoregm;
  assign w_aligned = (aluoutm[1:0] == 2'b00);

  // Gated with reset so both flags drop the instant reset rises.
  assign stallm    = ~reset & (((r_state == S_IDLE) & w_acc & w_aligned) |
                               (r_state == S_BUSY));
  assign misalignm = ~reset & (r_state == S_IDLE) & w_acc & ~w_aligned;

  assign bus_req   = r_req;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign readdatam = r_rdata;
  assign buserrm   = r_buserr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_is_load <= 1'b0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_rdata   <= 32'd0;
      r_buserr  <= 1'b0;
    end else begin
      r_buserr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            if (w_aligned) begin
              r_addr    <= aluoutm;
              r_wdata   <= writedatam;
              r_we      <= memwritem;
              r_is_load <= ~memwritem;
              r_req     <= 1'b1;
              r_cnt     <= 8'd0;
              r_state   <= S_BUSY;
            end else begin
              r_rdata <= 32'd0;
            end
          end
        end
        S_BUSY: begin
          // An ack on the final timeout cycle still counts as a completion.
          if (bus_ack) begin
            r_req <= 1'b0;
            if (r_is_load) r_rdata <= bus_rdata;
            r_state <= S_DONE;
          end else if (r_cnt == LP_LAST) begin
            r_req    <= 1'b0;
            r_rdata  <= 32'd0;
            r_buserr <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized instruction stream against a transaction-level model of the
// MEM-stage access unit, plus directed latency, fault and reset scenarios.
module tb_mem_access_unit;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwritem, memtoregm;
  logic [31:0] aluoutm, writedatam;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, readdatam;
  logic        stallm, misalignm, buserrm;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_rd;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .memwritem(memwritem), .memtoregm(memtoregm),
    .aluoutm(aluoutm), .writedatam(writedatam),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .readdatam(readdatam), .stallm(stallm),
    .misalignm(misalignm), .buserrm(buserrm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One pipeline instruction in MEM; dly = BUSY cycle carrying the ack,
  // dly > TO means the memory never answers.
  task automatic run_instr(input logic we, input logic re, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int dly);
    int n, n_stall, n_req;
    logic ack_ok;
    next_cycle();
    memwritem  = we;
    memtoregm  = re;
    aluoutm    = addr;
    writedatam = wdata;
    bus_ack    = 1'($urandom_range(0, 1));
    bus_rdata  = $urandom;
    #3;
    check("rd_hold", readdatam, exp_rd);
    check("buserr_idle", 32'(buserrm), 32'd0);
    if (!(we | re)) begin
      check("stall_none", 32'(stallm), 32'd0);
      check("misal_none", 32'(misalignm), 32'd0);
      check("req_none", 32'(bus_req), 32'd0);
    end else if (addr[1:0] != 2'b00) begin
      check("misal", 32'(misalignm), 32'd1);
      check("stall_misal", 32'(stallm), 32'd0);
      check("req_misal", 32'(bus_req), 32'd0);
      exp_rd = 32'd0;
    end else begin
      check("misal_ok", 32'(misalignm), 32'd0);
      n_stall = int'(stallm);
      n_req   = int'(bus_req);
      n = (dly <= TO) ? dly : TO;
      ack_ok = (dly <= TO);
      for (int k = 1; k <= n; k++) begin
        next_cycle();
        bus_ack   = (k == dly);
        bus_rdata = (k == dly) ? rdata : $urandom;
        #3;
        n_stall += int'(stallm);
        n_req   += int'(bus_req);
        check("bus_we", 32'(bus_we), 32'(we));
        check("bus_addr", bus_addr, addr);
        check("bus_wdata", bus_wdata, wdata);
        check("buserr_busy", 32'(buserrm), 32'd0);
      end
      if (ack_ok && !we) exp_rd = rdata;
      else if (!ack_ok) exp_rd = 32'd0;
      next_cycle();
      bus_ack   = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      #3;
      check("stall_done", 32'(stallm), 32'd0);
      check("req_done", 32'(bus_req), 32'd0);
      check("buserr_done", 32'(buserrm), 32'(!ack_ok));
      check("rd_done", readdatam, exp_rd);
      check("stall_cnt", 32'(n_stall), 32'(n + 1));
      check("req_cnt", 32'(n_req), 32'(n));
    end
  endtask

  task automatic reset_mid_busy();
    next_cycle();
    memwritem = 1'b0; memtoregm = 1'b1; aluoutm = 32'h40; bus_ack = 1'b0;
    #3;
    next_cycle();
    #3;
    next_cycle();
    #3;
    check("rst_req_before", 32'(bus_req), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_stall", 32'(stallm), 32'd0);
    check("rst_rd", readdatam, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    next_cycle();
    reset = 1'b0; memtoregm = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    #3;
    check("post_rst_req", 32'(bus_req), 32'd0);
    check("post_rst_stall", 32'(stallm), 32'd0);
    next_cycle();
    bus_ack = 1'b0;
    #3;
    check("post_rst_rd", readdatam, 32'd0);
    check("post_rst_req2", 32'(bus_req), 32'd0);
    exp_rd = 32'd0;
  endtask

  initial begin
    logic [31:0] a, w;
    int kind;
    reset = 1'b1;
    memwritem = 1'b0; memtoregm = 1'b0; aluoutm = 32'd0; writedatam = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    exp_rd = 32'd0;
    #2;
    check("reset_req", 32'(bus_req), 32'd0);
    check("reset_we", 32'(bus_we), 32'd0);
    check("reset_addr", bus_addr, 32'd0);
    check("reset_wdata", bus_wdata, 32'd0);
    check("reset_rd", readdatam, 32'd0);
    check("reset_stall", 32'(stallm), 32'd0);
    check("reset_flags", {30'd0, misalignm, buserrm}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    run_instr(1'b0, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    run_instr(1'b1, 1'b0, 32'h20, 32'h12345678, 32'h55555555, 1);
    run_instr(1'b0, 1'b1, 32'h103, 32'h0, 32'h0, 1);
    run_instr(1'b0, 1'b1, 32'h200, 32'h0, 32'h0, TO + 5);
    run_instr(1'b0, 1'b1, 32'h204, 32'h0, 32'hA5A5A5A5, TO);
    run_instr(1'b1, 1'b1, 32'h300, 32'hFEEDFACE, 32'h11111111, 2);
    run_instr(1'b1, 1'b0, 32'h400, 32'h0BADC0DE, 32'h0, 1);
    run_instr(1'b0, 1'b1, 32'h404, 32'h0, 32'h76543210, 1);
    reset_mid_busy();

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      a = $urandom;
      w = $urandom;
      if (kind < 2)
        run_instr(1'b0, 1'b0, a, w, $urandom, 1);
      else if (kind == 2)
        run_instr(1'($urandom_range(0, 1)), 1'b1, {a[31:2], 2'($urandom_range(1, 3))}, w, 32'h0, 1);
      else begin
        kind = $urandom_range(0, 2);
        run_instr(kind != 1, kind != 0, {a[31:2], 2'b00}, w, $urandom,
                  $urandom_range(1, TO + 3));
      end
    end

    next_cycle();
    memwritem = 1'b0; memtoregm = 1'b0; bus_ack = 1'b0;
    #3;
    check("rd_final", readdatam, exp_rd);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
